// File: rtl/jpeg_rle_pkg.sv
// Shared symbol kinds, FSM states and block constants for the JPEG run-length symbolizer.
package jpeg_rle_pkg;

    localparam int BLOCK_LEN = 64;
    localparam int ZRL_RUN   = 15;
    localparam int MAX_SIZE  = 11;
    localparam int INDEX_W   = $clog2(BLOCK_LEN);

    typedef enum logic [1:0] {
        SYM_AC,
        SYM_DC,
        SYM_ZRL,
        SYM_EOB
    } sym_kind_e;

    typedef enum logic [1:0] {
        ST_ACCEPT,
        ST_EMIT_ZRL,
        ST_EMIT_SYM,
        ST_EMIT_EOB
    } state_e;

    // Number of ZRL (16-zero) symbols needed ahead of a coefficient preceded by run zeros.
    function automatic logic [1:0] zrl_count(input logic [INDEX_W-1:0] run);
        return run[INDEX_W-1:4];
    endfunction

endpackage

// File: rtl/jpeg_size_amp.sv
// Combinational JPEG magnitude category (SIZE) and right-aligned amplitude bits of a signed value.
module jpeg_size_amp #(
    parameter int IN_W   = 12,
    parameter int SIZE_W = 4,
    parameter int AMP_W  = 12
) (
    input  logic signed [IN_W-1:0]   value_i,
    output logic        [SIZE_W-1:0] size_o,
    output logic        [AMP_W-1:0]  amp_o
);

    logic [IN_W-1:0] mag;
    logic [IN_W-1:0] raw;
    logic [IN_W-1:0] mask;

    // Negative values carry (v-1), i.e. the one's complement of |v|, in their low SIZE bits.
    always_comb begin
        mag    = value_i[IN_W-1] ? -value_i : value_i;
        raw    = value_i[IN_W-1] ? (value_i - IN_W'(1)) : value_i;
        size_o = '0;
        for (int i = 0; i < IN_W; i++) begin
            if (mag[i]) begin
                size_o = SIZE_W'(i + 1);
            end
        end
        for (int i = 0; i < IN_W; i++) begin
            mask[i] = (i < int'(size_o));
        end
        amp_o = AMP_W'(raw & mask);
    end

endmodule

// File: rtl/jpeg_rle_symbolizer.sv
// Turns 64 zigzag-ordered quantized coefficients per block into JPEG RUN/SIZE/amplitude symbols.
// Define JPEG_RLE_DC_DIFF_EN to encode DC as the difference from the previous block's DC.
module jpeg_rle_symbolizer
    import jpeg_rle_pkg::*;
#(
    parameter int COEF_W = 12,
    parameter int SIZE_W = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [COEF_W-1:0] in_coef,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic        [3:0]        out_run,
    output logic        [SIZE_W-1:0] out_size,
    output logic        [COEF_W-1:0] out_amp,
    output logic                     out_is_dc,
    output logic                     out_is_zrl,
    output logic                     out_is_eob,
    output logic                     out_last
);

    localparam logic [INDEX_W-1:0] LAST_IDX  = INDEX_W'(BLOCK_LEN - 1);
    localparam logic [3:0]         ZRL_RUN_V = 4'(ZRL_RUN);

    state_e              state_q, state_d;
    logic [INDEX_W-1:0]  index_q, index_d;
    logic [INDEX_W-1:0]  zero_run_q, zero_run_d;
    logic [1:0]          zrl_cnt_q, zrl_cnt_d;

    logic [3:0]          pend_run_q, pend_run_d;
    logic [SIZE_W-1:0]   pend_size_q, pend_size_d;
    logic [COEF_W-1:0]   pend_amp_q, pend_amp_d;
    logic                pend_last_q, pend_last_d;

    logic                out_valid_q, out_valid_d;
    sym_kind_e           out_kind_q, out_kind_d;
    logic [3:0]          out_run_q, out_run_d;
    logic [SIZE_W-1:0]   out_size_q, out_size_d;
    logic [COEF_W-1:0]   out_amp_q, out_amp_d;
    logic                out_last_q, out_last_d;

    logic                ld_en;
    sym_kind_e           ld_kind;
    logic [3:0]          ld_run;
    logic [SIZE_W-1:0]   ld_size;
    logic [COEF_W-1:0]   ld_amp;
    logic                ld_last;

    logic                out_free;
    logic                accept;
    logic                last_idx;
    logic                coef_zero;
    logic [SIZE_W-1:0]   ac_size, dc_size;
    logic [COEF_W-1:0]   ac_amp, dc_amp;

`ifdef JPEG_RLE_DC_DIFF_EN
    localparam int DC_W = COEF_W + 1;
    logic signed [COEF_W-1:0] pred_q;
    logic signed [DC_W-1:0]   dc_value;

    assign dc_value = {in_coef[COEF_W-1], in_coef} - {pred_q[COEF_W-1], pred_q};

    // Predictor tracks the raw DC of the most recently accepted block.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pred_q <= '0;
        end else if (accept && (index_q == '0)) begin
            pred_q <= in_coef;
        end
    end
`else
    localparam int DC_W = COEF_W;
    logic signed [DC_W-1:0] dc_value;

    assign dc_value = in_coef;
`endif

    jpeg_size_amp #(
        .IN_W   (COEF_W),
        .SIZE_W (SIZE_W),
        .AMP_W  (COEF_W)
    ) u_ac_size_amp (
        .value_i (in_coef),
        .size_o  (ac_size),
        .amp_o   (ac_amp)
    );

    jpeg_size_amp #(
        .IN_W   (DC_W),
        .SIZE_W (SIZE_W),
        .AMP_W  (COEF_W)
    ) u_dc_size_amp (
        .value_i (dc_value),
        .size_o  (dc_size),
        .amp_o   (dc_amp)
    );

    assign out_free  = !out_valid_q || out_ready;
    assign in_ready  = !rst && (state_q == ST_ACCEPT) && out_free;
    assign accept    = in_valid && in_ready;
    assign last_idx  = (index_q == LAST_IDX);
    assign coef_zero = (in_coef == '0);

    // Sequencing: ld_* describes the symbol, if any, that enters the output register this cycle.
    always_comb begin
        state_d     = state_q;
        index_d     = index_q;
        zero_run_d  = zero_run_q;
        zrl_cnt_d   = zrl_cnt_q;
        pend_run_d  = pend_run_q;
        pend_size_d = pend_size_q;
        pend_amp_d  = pend_amp_q;
        pend_last_d = pend_last_q;
        ld_en       = 1'b0;
        ld_kind     = SYM_AC;
        ld_run      = '0;
        ld_size     = '0;
        ld_amp      = '0;
        ld_last     = 1'b0;

        case (state_q)
            ST_ACCEPT: begin
                if (accept) begin
                    index_d = last_idx ? '0 : (index_q + INDEX_W'(1));
                    if (index_q == '0) begin
                        ld_en   = 1'b1;
                        ld_kind = SYM_DC;
                        ld_size = dc_size;
                        ld_amp  = dc_amp;
                    end else if (coef_zero) begin
                        if (last_idx) begin
                            zero_run_d = '0;
                            state_d    = ST_EMIT_EOB;
                        end else begin
                            zero_run_d = zero_run_q + INDEX_W'(1);
                        end
                    end else begin
                        zero_run_d = '0;
                        if (zrl_count(zero_run_q) != 2'd0) begin
                            state_d     = ST_EMIT_ZRL;
                            zrl_cnt_d   = zrl_count(zero_run_q);
                            pend_run_d  = zero_run_q[3:0];
                            pend_size_d = ac_size;
                            pend_amp_d  = ac_amp;
                            pend_last_d = last_idx;
                        end else begin
                            ld_en   = 1'b1;
                            ld_kind = SYM_AC;
                            ld_run  = zero_run_q[3:0];
                            ld_size = ac_size;
                            ld_amp  = ac_amp;
                            ld_last = last_idx;
                        end
                    end
                end
            end
            ST_EMIT_ZRL: begin
                if (out_free) begin
                    ld_en     = 1'b1;
                    ld_kind   = SYM_ZRL;
                    ld_run    = ZRL_RUN_V;
                    zrl_cnt_d = zrl_cnt_q - 2'd1;
                    if (zrl_cnt_q == 2'd1) begin
                        state_d = ST_EMIT_SYM;
                    end
                end
            end
            ST_EMIT_SYM: begin
                if (out_free) begin
                    ld_en   = 1'b1;
                    ld_kind = SYM_AC;
                    ld_run  = pend_run_q;
                    ld_size = pend_size_q;
                    ld_amp  = pend_amp_q;
                    ld_last = pend_last_q;
                    state_d = ST_ACCEPT;
                end
            end
            ST_EMIT_EOB: begin
                if (out_free) begin
                    ld_en   = 1'b1;
                    ld_kind = SYM_EOB;
                    ld_last = 1'b1;
                    state_d = ST_ACCEPT;
                end
            end
            default: begin
                state_d = ST_ACCEPT;
            end
        endcase
    end

    // Output stage holds its fields until consumed; a new symbol only loads when the slot is free.
    always_comb begin
        out_valid_d = out_valid_q && !out_ready;
        out_kind_d  = out_kind_q;
        out_run_d   = out_run_q;
        out_size_d  = out_size_q;
        out_amp_d   = out_amp_q;
        out_last_d  = out_last_q;
        if (ld_en) begin
            out_valid_d = 1'b1;
            out_kind_d  = ld_kind;
            out_run_d   = ld_run;
            out_size_d  = ld_size;
            out_amp_d   = ld_amp;
            out_last_d  = ld_last;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_ACCEPT;
            index_q     <= '0;
            zero_run_q  <= '0;
            zrl_cnt_q   <= '0;
            pend_run_q  <= '0;
            pend_size_q <= '0;
            pend_amp_q  <= '0;
            pend_last_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_kind_q  <= SYM_AC;
            out_run_q   <= '0;
            out_size_q  <= '0;
            out_amp_q   <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            index_q     <= index_d;
            zero_run_q  <= zero_run_d;
            zrl_cnt_q   <= zrl_cnt_d;
            pend_run_q  <= pend_run_d;
            pend_size_q <= pend_size_d;
            pend_amp_q  <= pend_amp_d;
            pend_last_q <= pend_last_d;
            out_valid_q <= out_valid_d;
            out_kind_q  <= out_kind_d;
            out_run_q   <= out_run_d;
            out_size_q  <= out_size_d;
            out_amp_q   <= out_amp_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_run    = out_run_q;
    assign out_size   = out_size_q;
    assign out_amp    = out_amp_q;
    assign out_last   = out_last_q;
    assign out_is_dc  = (out_kind_q == SYM_DC);
    assign out_is_zrl = (out_kind_q == SYM_ZRL);
    assign out_is_eob = (out_kind_q == SYM_EOB);

endmodule

// File: tb/tb_jpeg_rle_symbolizer.sv
// Self-checking bench for jpeg_rle_symbolizer: size/amp table, directed corner blocks, and
// randomized blocks under back-pressure compared against a symbol-level JPEG RLE model.
module tb_jpeg_rle_symbolizer;

    localparam int COEF_W = 12;
    localparam int SIZE_W = 4;
    localparam int NVEC   = 14;

    // kind: 0=AC, 1=DC, 2=ZRL, 3=EOB
    typedef struct {
        int kind;
        int run;
        int size;
        int amp;
        int last;
    } symT;

    typedef struct {
        int value;
        int expSize;
        int expAmp;
    } vecT;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [COEF_W-1:0] in_coef;
    logic              out_valid;
    logic              out_ready;
    logic [3:0]        out_run;
    logic [SIZE_W-1:0] out_size;
    logic [COEF_W-1:0] out_amp;
    logic              out_is_dc;
    logic              out_is_zrl;
    logic              out_is_eob;
    logic              out_last;

    int  total = 0;
    int  bad = 0;
    bit  stallMode = 0;
    bit  gapMode = 0;
    int  modelPred = 0;
    int  blk[64];
    symT gotQ[$];
    symT expQ[$];
    vecT vecs[NVEC];

    jpeg_rle_symbolizer #(
        .COEF_W (COEF_W),
        .SIZE_W (SIZE_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_coef    (in_coef),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_run    (out_run),
        .out_size   (out_size),
        .out_amp    (out_amp),
        .out_is_dc  (out_is_dc),
        .out_is_zrl (out_is_zrl),
        .out_is_eob (out_is_eob),
        .out_last   (out_last)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got no end, expected end of test");
        $fatal(1, "[TB] watchdog expired");
    end

    // Downstream ready: always high unless the stall phase is running.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = stallMode ? ($urandom_range(0, 99) < 60) : 1'b1;
        end
    end

    function automatic symT mkSym(int kind, int run, int size, int amp, int last);
        symT s;
        s.kind = kind;
        s.run  = run;
        s.size = size;
        s.amp  = amp;
        s.last = last;
        return s;
    endfunction

    function automatic symT curSym();
        int k;
        k = out_is_dc ? 1 : (out_is_zrl ? 2 : (out_is_eob ? 3 : 0));
        return mkSym(k, int'(out_run), int'(out_size), int'(out_amp), int'(out_last));
    endfunction

    function automatic bit symEq(symT a, symT b);
        return (a.kind == b.kind) && (a.run == b.run) && (a.size == b.size) &&
               (a.amp == b.amp) && (a.last == b.last);
    endfunction

    function automatic void checkVal(string name, int got, int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endfunction

    function automatic void checkSym(string name, symT got, symT exp);
        total++;
        if (!symEq(got, exp)) begin
            bad++;
            $display("[TB] FAIL %s: got kind=%0d run=%0d size=%0d amp=%0d last=%0d, expected kind=%0d run=%0d size=%0d amp=%0d last=%0d",
                     name, got.kind, got.run, got.size, got.amp, got.last,
                     exp.kind, exp.run, exp.size, exp.amp, exp.last);
        end
    endfunction

    function automatic void pushExp(int kind, int run, int size, int amp, int last);
        expQ.push_back(mkSym(kind, run, size, amp, last));
    endfunction

    // Reference model: JPEG category and amplitude from plain integer arithmetic.
    function automatic int bitLen(int v);
        int m;
        int n;
        m = (v < 0) ? -v : v;
        n = 0;
        while (m > 0) begin
            n++;
            m = m >>> 1;
        end
        return n;
    endfunction

    function automatic int ampOf(int v);
        int n;
        n = bitLen(v);
        return (v >= 0) ? v : ((v - 1) & ((1 << n) - 1));
    endfunction

    // Reference model: whole-block JPEG run-length symbol list appended to expQ.
    function automatic void modelBlock();
        int dcVal;
        int run;
`ifdef JPEG_RLE_DC_DIFF_EN
        dcVal     = blk[0] - modelPred;
        modelPred = blk[0];
`else
        dcVal = blk[0];
`endif
        pushExp(1, 0, bitLen(dcVal), ampOf(dcVal), 0);
        run = 0;
        for (int k = 1; k < 64; k++) begin
            if (blk[k] == 0) begin
                run++;
            end else begin
                while (run >= 16) begin
                    pushExp(2, 15, 0, 0, 0);
                    run -= 16;
                end
                pushExp(0, run, bitLen(blk[k]), ampOf(blk[k]), (k == 63) ? 1 : 0);
                run = 0;
            end
        end
        if (blk[63] == 0) begin
            pushExp(3, 0, 0, 0, 1);
        end
    endfunction

    // Monitor: records transfers, checks hold-stability under stall and in_ready during ZRL.
    initial begin
        symT cur;
        symT held;
        bit  stalled;
        stalled = 1'b0;
        held = mkSym(0, 0, 0, 0, 0);
        forever begin
            @(negedge clk);
            if (rst) begin
                stalled = 1'b0;
            end else begin
                cur = curSym();
                if (stalled) begin
                    total++;
                    if (!out_valid || !symEq(cur, held)) begin
                        bad++;
                        $display("[TB] FAIL stall hold: got valid=%0d kind=%0d run=%0d size=%0d amp=%0d, expected valid=1 kind=%0d run=%0d size=%0d amp=%0d",
                                 out_valid, cur.kind, cur.run, cur.size, cur.amp,
                                 held.kind, held.run, held.size, held.amp);
                    end
                end
                if (out_valid && out_is_zrl) begin
                    checkVal("in_ready during ZRL", int'(in_ready), 0);
                end
                if (out_valid && out_ready) begin
                    gotQ.push_back(cur);
                end
                stalled = out_valid && !out_ready;
                held = cur;
            end
        end
    end

    task automatic sendCoef(input int v);
        int waited;
        waited = 0;
        in_valid = 1'b1;
        in_coef  = COEF_W'(v);
        @(negedge clk);
        while (!in_ready && waited < 500) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            bad++;
            total++;
            $display("[TB] FAIL input handshake: got in_ready=0 for %0d cycles, expected in_ready=1", waited);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic applyStimulus();
        for (int k = 0; k < 64; k++) begin
            if (gapMode && ($urandom_range(0, 3) == 0)) begin
                in_coef = COEF_W'($urandom);
                repeat ($urandom_range(1, 2)) @(posedge clk);
                #1;
            end
            sendCoef(blk[k]);
        end
    endtask

    task automatic checkOutput(input string name);
        int waited;
        waited = 0;
        while (gotQ.size() < expQ.size() && waited < 5000) begin
            @(negedge clk);
            waited++;
        end
        repeat (4) @(negedge clk);
        checkVal({name, " symbol count"}, gotQ.size(), expQ.size());
        for (int i = 0; i < expQ.size() && i < gotQ.size(); i++) begin
            checkSym($sformatf("%s[%0d]", name, i), gotQ[i], expQ[i]);
        end
        gotQ.delete();
        expQ.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        gotQ.delete();
        expQ.delete();
        modelPred = 0;
    endtask

    task automatic clearBlk();
        for (int k = 0; k < 64; k++) begin
            blk[k] = 0;
        end
    endtask

    task automatic randomBlk();
        bit sparse;
        sparse = ($urandom_range(0, 2) == 0);
        blk[0] = int'($urandom_range(0, 2000)) - 1000;
        for (int k = 1; k < 64; k++) begin
            if ($urandom_range(0, 99) < (sparse ? 96 : 70)) begin
                blk[k] = 0;
            end else begin
                blk[k] = int'($urandom_range(0, 2000)) - 1000;
            end
        end
        if ($urandom_range(0, 3) == 0) begin
            blk[63] = int'($urandom_range(1, 50));
        end
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_coef  = '0;

        vecs[0]  = '{1, 1, 1};
        vecs[1]  = '{-1, 1, 0};
        vecs[2]  = '{2, 2, 2};
        vecs[3]  = '{-2, 2, 1};
        vecs[4]  = '{3, 2, 3};
        vecs[5]  = '{-3, 2, 0};
        vecs[6]  = '{7, 3, 7};
        vecs[7]  = '{-8, 4, 7};
        vecs[8]  = '{255, 8, 255};
        vecs[9]  = '{-256, 9, 255};
        vecs[10] = '{1023, 10, 1023};
        vecs[11] = '{-1024, 11, 1023};
        vecs[12] = '{2047, 11, 2047};
        vecs[13] = '{-2048, 12, 2047};

        repeat (2) @(negedge clk);
        checkVal("reset out_valid", int'(out_valid), 0);
        checkVal("reset in_ready", int'(in_ready), 0);
        checkVal("reset fields", int'({out_run, out_size, out_amp, out_is_dc, out_is_zrl, out_is_eob, out_last}), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Category/amplitude table, each value placed at AC index 1 of an otherwise empty block.
        for (int i = 0; i < NVEC; i++) begin
            clearBlk();
            blk[1] = vecs[i].value;
            applyStimulus();
            pushExp(1, 0, 0, 0, 0);
            pushExp(0, 0, vecs[i].expSize, vecs[i].expAmp, 0);
            pushExp(3, 0, 0, 0, 1);
            checkOutput($sformatf("vec%0d(%0d)", i, vecs[i].value));
        end

        // DC only: DC then EOB, nothing else.
        doReset();
        clearBlk();
        blk[0] = 5;
        applyStimulus();
        pushExp(1, 0, 3, 5, 0);
        pushExp(3, 0, 0, 0, 1);
        checkOutput("dc5_eob");

        // Negative DC, AC[1]=1, with one-cycle latency check on the AC symbol.
        doReset();
        sendCoef(-3);
        sendCoef(1);
        checkVal("ac latency valid", int'(out_valid), 1);
        checkVal("ac latency size", int'(out_size), 1);
        checkVal("ac latency is_dc", int'(out_is_dc), 0);
        for (int k = 2; k < 64; k++) begin
            sendCoef(0);
        end
        pushExp(1, 0, 2, 0, 0);
        pushExp(0, 0, 1, 1, 0);
        pushExp(3, 0, 0, 0, 1);
        checkOutput("dcm3_ac1");

        // 33 zeros then -1: two ZRLs and a run-1 symbol.
        doReset();
        clearBlk();
        blk[34] = -1;
        applyStimulus();
        pushExp(1, 0, 0, 0, 0);
        pushExp(2, 15, 0, 0, 0);
        pushExp(2, 15, 0, 0, 0);
        pushExp(0, 1, 1, 0, 0);
        pushExp(3, 0, 0, 0, 1);
        checkOutput("zrl2");

        // 62 zeros then 7 at the last index: three ZRLs, final symbol marked last, no EOB.
        doReset();
        clearBlk();
        blk[63] = 7;
        applyStimulus();
        pushExp(1, 0, 0, 0, 0);
        pushExp(2, 15, 0, 0, 0);
        pushExp(2, 15, 0, 0, 0);
        pushExp(2, 15, 0, 0, 0);
        pushExp(0, 14, 3, 7, 1);
        checkOutput("zrl3_last");

        // Reset mid-block at index 20 while a symbol is being presented.
        doReset();
        for (int k = 0; k < 20; k++) begin
            sendCoef((k == 0) ? 4 : ((k % 3 == 1) ? k : 0));
        end
        checkVal("pre-reset out_valid", int'(out_valid), 1);
        #2;
        rst = 1'b1;
        #1;
        checkVal("mid reset out_valid", int'(out_valid), 0);
        checkVal("mid reset in_ready", int'(in_ready), 0);
        checkVal("mid reset fields", int'({out_run, out_size, out_amp, out_is_dc, out_is_zrl, out_is_eob, out_last}), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        gotQ.delete();
        expQ.delete();
        clearBlk();
        blk[0] = 10;
        applyStimulus();
        pushExp(1, 0, 4, 10, 0);
        pushExp(3, 0, 0, 0, 1);
        checkOutput("post_reset_dc10");
        clearBlk();
        blk[0] = 7;
        applyStimulus();
`ifdef JPEG_RLE_DC_DIFF_EN
        pushExp(1, 0, 2, 0, 0);
`else
        pushExp(1, 0, 3, 7, 0);
`endif
        pushExp(3, 0, 0, 0, 1);
        checkOutput("post_reset_dc7");

        // Randomized blocks with input gaps and downstream stalls against the model.
        doReset();
        stallMode = 1'b1;
        gapMode   = 1'b1;
        for (int b = 0; b < 100; b++) begin
            randomBlk();
            modelBlock();
            applyStimulus();
        end
        checkOutput("random");
        stallMode = 1'b0;
        gapMode   = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
